// File: rtl/data_sync_tx_pkg.sv
// rtl/data_sync_tx_pkg.sv - shared state encoding and counter sizing for the CDC transmit scheduler
package data_sync_tx_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    HOLD        = 3'd1,
    GAP         = 3'd2,
    WAIT_ACK_HI = 3'd3,
    WAIT_ACK_LO = 3'd4
  } tx_state_e;

  // Counter must hold max(HOLD_CYCLES, GAP_CYCLES)-1; sized as clog2(max+1).
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; search starts one past the pointer
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    found     = 1'b0;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = IDW'((int'(ptr) + k) % int'(NUM_REQ));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/data_sync_tx_ctrl.sv
// rtl/data_sync_tx_ctrl.sv - round-robin transmit scheduler feeding one bus+enable CDC crossing
// Optional: DATA_SYNC_TX_ACK_HANDSHAKE_EN selects a four-phase ack handshake instead of hold/gap timers.
module data_sync_tx_ctrl
  import data_sync_tx_pkg::*;
#(
  parameter  int unsigned WIDTH       = 8,
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned HOLD_CYCLES = 6,
  parameter  int unsigned GAP_CYCLES  = 4,
  localparam int unsigned IDW         = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     sync_ack,
  output logic [WIDTH-1:0]         unsync_bus,
  output logic                     bus_enable,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  tx_state_e        state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             en_q, en_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]   arb_idx;
  logic [WIDTH-1:0] sel_data;
  logic             accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign accept = (state_q == IDLE) && (|arb_grant);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_grant[i]) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

`ifndef DATA_SYNC_TX_ACK_HANDSHAKE_EN
  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_sync_ack;

  assign unused_sync_ack = sync_ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = HOLD;
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      end
      HOLD: if (cnt_q == '0) begin
        state_d = GAP;
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      GAP: if (cnt_q == '0) state_d = IDLE;
           else cnt_d = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  // Ack is only looked at in the WAIT states, so a stale high ack in IDLE is harmless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept)    state_d = WAIT_ACK_HI;
      WAIT_ACK_HI: if (sync_ack)  state_d = WAIT_ACK_LO;
      WAIT_ACK_LO: if (!sync_ack) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end
`endif

  always_comb begin
    en_d  = (state_d == HOLD) || (state_d == WAIT_ACK_HI);
    bus_d = accept ? sel_data : bus_q;
    gid_d = accept ? arb_idx  : gid_q;
    ptr_d = accept ? arb_idx  : ptr_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      bus_q   <= '0;
      gid_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bus_q   <= bus_d;
      gid_q   <= gid_d;
      en_q    <= en_d;
    end
  end

  assign req_ready  = (state_q == IDLE) ? arb_grant : '0;
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_sync_tx_ctrl.sv
// tb/tb_data_sync_tx_ctrl.sv - directed self-checking bench for data_sync_tx_ctrl
module tb_data_sync_tx_ctrl;

  logic        CLK;
  logic        RST;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        sync_ack;
  logic [7:0]  unsync_bus;
  logic        bus_enable;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  data_sync_tx_ctrl #(.WIDTH(8), .NUM_REQ(4), .HOLD_CYCLES(6), .GAP_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .sync_ack   (sync_ack),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST       = 1'b0;
    req_valid = '0;
    sync_ack  = 1'b0;
    repeat (2) step();
    RST = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      step();
      guard++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int hi_cnt, lo_cnt, bad, guard, n_acc, last_cyc, cyc, exp_idx;
  logic acc_pending;

  initial begin
    RST = 1'b0; req_valid = '0; req_data = '0; sync_ack = 1'b0;
    step(); step();
    check("rst_bus",   32'(unsync_bus), 32'd0);
    check("rst_en",    32'(bus_enable), 32'd0);
    check("rst_gid",   32'(grant_id),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ready", 32'(req_ready),  32'd0);
    RST = 1'b1;
    step();

`ifndef DATA_SYNC_TX_ACK_HANDSHAKE_EN
    // single word from requester 1
    req_valid = 4'b0010; req_data[15:8] = 8'hA5;
    #1 check("t1_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("t1_bus", 32'(unsync_bus), 32'hA5);
    check("t1_gid", 32'(grant_id), 32'd1);
    hi_cnt = 0; lo_cnt = 0; guard = 0;
    while (bus_enable && guard < 50) begin hi_cnt++; step(); guard++; end
    while (busy && !bus_enable && guard < 50) begin lo_cnt++; step(); guard++; end
    check("t1_hold_len", 32'(hi_cnt), 32'd6);
    check("t1_gap_len",  32'(lo_cnt), 32'd4);
    check("t1_bus_kept", 32'(unsync_bus), 32'hA5);

    // all requesters valid: rotate 0,1,2,3,0 at 11-cycle spacing
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    #1;
    n_acc = 0; cyc = 0; last_cyc = 0; acc_pending = 1'b0; exp_idx = 0;
    while (n_acc < 5 && cyc < 200) begin
      if (|(req_ready & req_valid)) begin
        exp_idx = n_acc % 4;
        check("rr_order", 32'(req_ready), 32'(1) << exp_idx);
        if (n_acc > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd11);
        last_cyc = cyc; acc_pending = 1'b1; n_acc++;
      end
      step(); cyc++;
      if (acc_pending) begin
        check("rr_data", 32'(unsync_bus), 32'h10 + 32'(exp_idx));
        check("rr_gid",  32'(grant_id),   32'(exp_idx));
        acc_pending = 1'b0;
      end
    end
    check("rr_count", 32'(n_acc), 32'd5);
    req_valid = '0;
    wait_idle("rr_idle");

    // req 2 arrives while word 0x55 is in flight
    do_reset();
    req_valid = 4'b0001; req_data[7:0] = 8'h55;
    step();
    req_valid = 4'b0100; req_data[23:16] = 8'h77;
    #1;
    bad = 0; guard = 0;
    while (busy && guard < 50) begin
      if (req_ready != 4'b0) bad++;
      if (unsync_bus != 8'h55) bad++;
      step(); guard++;
    end
    check("t3_blocked",    32'(bad),   32'd0);
    check("t3_busy_len",   32'(guard), 32'd10);
    check("t3_ready_idle", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    check("t3_bus2", 32'(unsync_bus), 32'h77);
    check("t3_gid2", 32'(grant_id),   32'd2);
    wait_idle("t3_idle");

    // async reset in the middle of HOLD
    do_reset();
    req_valid = 4'b0010; req_data[15:8] = 8'h99;
    step();
    req_valid = '0;
    step(); step();
    check("t4_pre_en", 32'(bus_enable), 32'd1);
    RST = 1'b0;
    #1;
    check("t4_en",    32'(bus_enable), 32'd0);
    check("t4_bus",   32'(unsync_bus), 32'd0);
    check("t4_gid",   32'(grant_id),   32'd0);
    check("t4_busy",  32'(busy),       32'd0);
    check("t4_ready", 32'(req_ready),  32'd0);
    step();
    RST = 1'b1;
    req_valid = 4'b1001; req_data[7:0] = 8'h40; req_data[31:24] = 8'h43;
    #1 check("t4_ptr_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("t4_gid_after", 32'(grant_id),   32'd0);
    check("t4_bus_after", 32'(unsync_bus), 32'h40);

    // req 3 withdraws before it can win
    req_valid = 4'b1000; req_data[31:24] = 8'hEE;
    repeat (3) step();
    req_valid = '0;
    wait_idle("t6_idle");
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus_enable || busy || (req_ready != 4'b0)) bad++;
      step();
    end
    check("t6_quiet", 32'(bad), 32'd0);
    check("t6_gid",   32'(grant_id),   32'd0);
    check("t6_bus",   32'(unsync_bus), 32'h40);
`else
    // four-phase ack handshake with word 0x3C
    do_reset();
    sync_ack = 1'b1;
    #1 check("hs_ack_idle", 32'(busy), 32'd0);
    sync_ack = 1'b0;
    req_valid = 4'b0001; req_data[7:0] = 8'h3C;
    step();
    req_valid = '0;
    check("hs_bus", 32'(unsync_bus), 32'h3C);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (!bus_enable) bad++;
      step();
    end
    check("hs_en_held", 32'(bad), 32'd0);
    sync_ack = 1'b1;
    #1 check("hs_en_pre", 32'(bus_enable), 32'd1);
    step();
    check("hs_en_drop", 32'(bus_enable), 32'd0);
    check("hs_busy",    32'(busy),       32'd1);
    req_valid = 4'b0001;
    #1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (req_ready != 4'b0) bad++;
      step();
    end
    check("hs_blocked", 32'(bad), 32'd0);
    sync_ack = 1'b0;
    step();
    check("hs_ready_again", 32'(req_ready), 32'h1);
    req_valid = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
